// File: rtl/decoder_dense_acc.sv
`default_nettype none
// ============================================================================
// Module      : decoder_dense_acc
// Description : Dense-layer neuron accumulator. Sums N_IN signed products on
//               top of a bias, then rounds, rescales, saturates and optionally
//               applies ReLU before presenting one activation per neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_dense_acc #(
    parameter int PROD_WIDTH = 23,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int N_IN       = 64,
    parameter int SHIFT      = 6,
    parameter int RELU       = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    input  logic [OUT_WIDTH-1:0]  bias_data,
    output logic [OUT_WIDTH-1:0]  out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  ovf_flag
);

    // Beat counter only needs to reach N_IN-1.
    localparam int c_cnt_w = $clog2(N_IN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_IN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Rounding constant and saturation bounds, one bit wider than the
    // accumulator so the rounding add can never wrap.
    localparam logic signed [ACC_WIDTH:0] c_half =
        (ACC_WIDTH+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_WIDTH:0] c_out_max =
        (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] c_out_min =
        (ACC_WIDTH+1)'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_cnt_w-1:0]            r_count;
    logic signed [ACC_WIDTH-1:0]   r_acc;

    logic                          w_beat;
    logic                          w_last;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_bias_ext;
    logic signed [ACC_WIDTH:0]     w_round;
    logic signed [ACC_WIDTH:0]     w_shifted;
    logic                          w_sat_hi;
    logic                          w_sat_lo;
    logic [OUT_WIDTH-1:0]          w_result;

    // A beat is taken only while accumulating and not held in reset; this
    // mirrors prod_tready without reading the port back.
    assign w_beat = prod_tvalid && (r_state == ST_ACC) && !ap_rst;
    assign w_last = w_beat && (r_count == c_cnt_last);

    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
    assign w_bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_data[OUT_WIDTH-1]}}, bias_data};

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        prod_tready = 1'b0;
        out_tvalid  = 1'b0;
        case (r_state)
            ST_ACC: begin
                prod_tready = !ap_rst;
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_tvalid = 1'b1;
                if (out_tready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // Accumulator and beat counter; the first beat reloads from the bias so
    // no separate clear cycle is needed between neurons.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_count <= c_cnt_zero;
            r_acc   <= '0;
        end else if (w_beat) begin
            if (r_count == c_cnt_zero) begin
                r_acc <= (w_bias_ext <<< SHIFT) + w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (r_count == c_cnt_last) begin
                r_count <= c_cnt_zero;
            end else begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    // Round-half-up, arithmetic rescale, saturate, then optional ReLU.
    always_comb begin
        w_round   = $signed({r_acc[ACC_WIDTH-1], r_acc}) + c_half;
        w_shifted = w_round >>> SHIFT;
        w_sat_hi  = (w_shifted > c_out_max);
        w_sat_lo  = (w_shifted < c_out_min);
        w_result  = w_shifted[OUT_WIDTH-1:0];
        if (w_sat_hi) begin
            w_result = c_out_max[OUT_WIDTH-1:0];
        end else if (w_sat_lo) begin
            w_result = c_out_min[OUT_WIDTH-1:0];
        end
        if ((RELU != 0) && w_result[OUT_WIDTH-1]) begin
            w_result = '0;
        end
    end

    // Result register and sticky overflow, both updated only in FIN so the
    // presented result stays stable while waiting for out_tready.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_tdata <= '0;
            ovf_flag  <= 1'b0;
        end else if (r_state == ST_FIN) begin
            out_tdata <= w_result;
            if (w_sat_hi || w_sat_lo) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/decoder_dense_acc.md
DECODER_DENSE_ACC -- requirements
Module: decoder_dense_acc

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 23: width of the signed product input from the 16s x 7ns multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: internal accumulator width.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: signed output activation width.
REQ-004 SHALL have parameter N_IN, default 64: products per output neuron (range 2..256).
REQ-005 SHALL have parameter SHIFT, default 6: fractional bits removed before output (range 1..15).
REQ-006 SHALL have parameter RELU, default 1: 1 = apply ReLU, 0 = pass signed value.
REQ-007 SHALL have port ap_clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port ap_rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port prod_tdata, input, PROD_WIDTH: signed product, two's complement.
REQ-010 SHALL have port prod_tvalid, input, 1: product valid.
REQ-011 SHALL have port prod_tready, output, 1: block accepts a product.
REQ-012 SHALL have port bias_data, input, OUT_WIDTH: signed bias in output Q format.
REQ-013 SHALL have port out_tdata, output, OUT_WIDTH: neuron result.
REQ-014 SHALL have port out_tvalid, output, 1: result valid.
REQ-015 SHALL have port out_tready, input, 1: consumer accepts result.
REQ-016 SHALL have port ovf_flag, output, 1: sticky saturation indicator.

Function
REQ-017 SHALL implement FSM states ACC, FIN, OUT.
REQ-018 ACC: prod_tready=1; a beat is accepted when prod_tvalid && prod_tready.
REQ-019 First beat of a neuron (count=0) SHALL load acc = sext(bias_data)<<SHIFT + sext(prod_tdata); bias_data is sampled only on this beat.
REQ-020 Later beats SHALL do acc = acc + sext(prod_tdata); count increments per accepted beat.
REQ-021 Accepting beat N_IN-1 SHALL move ACC->FIN and clear count to 0.
REQ-022 FIN (exactly one cycle): r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic); saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; if RELU=1 and result < 0, result = 0; register into out_tdata; go to OUT.
REQ-023 Saturation in FIN SHALL set ovf_flag; it stays set until ap_rst.
REQ-024 OUT: out_tvalid=1, out_tdata held stable; on out_tready=1 go to ACC next cycle.
REQ-025 prod_tready SHALL be 0 in FIN and OUT; input beats are never dropped or double-counted.
REQ-026 Latency: last product accepted in cycle t -> out_tvalid=1 in cycle t+2; with out_tready held high, next neuron's first beat is accepted in cycle t+3.
REQ-027 out_tvalid SHALL NOT drop without an out_tready handshake.
REQ-028 Gaps in prod_tvalid SHALL stall accumulation without changing acc or count.

Reset
REQ-029 While ap_rst=1 on a rising edge: state=ACC, count=0, acc=0, out_tdata=0, out_tvalid=0, ovf_flag=0; prod_tready=0 in the reset cycle, 1 in the first cycle after release.
REQ-030 Reset mid-neuron SHALL discard the partial sum; the first beat after release is treated as count=0.

Verification
REQ-031 N_IN=4, SHIFT=6, RELU=1, bias=1, products 64,64,64,64 -> out_tdata=5, ovf_flag=0, out_tvalid at t+2.
REQ-032 N_IN=4, bias=0, four products 4194303 -> out_tdata=32767, ovf_flag=1, still 1 after next unsaturated neuron.
REQ-033 N_IN=4, RELU=1, bias=0, four products -640 -> out_tdata=0; same with RELU=0 -> out_tdata=-40 (0xFFD8).
REQ-034 out_tready low 5 cycles after out_tvalid -> out_tvalid and out_tdata stable, prod_tready=0 throughout; result consumed on 6th cycle, prod_tready=1 next cycle.
REQ-035 Assert ap_rst after 2 of 4 beats (values 1000), then 4 beats of 64 with bias 1 -> out_tdata=5 (partial sum discarded).
REQ-036 Random prod_tvalid gaps (~50%) over 100 neurons vs reference model -> all results match, none lost or duplicated.
